mcp_launch_ctrl: RTL and testbench
==================================

// Module: mcp_launch_ctrl
// PURPOSE
//  Launch side of a multicycle-path (MCP) transfer. Accepts one data word over a
//  valid/ready handshake and registers it in a launch flop. Holds that flop stable
//  for MCP_CYCLES edges and then HOLD_CYCLES further edges.
//  Pulses cap_en for exactly one cycle so the destination captures on the MCP-th
//  edge after launch. cap_en drives the destination clock-gate enable or flop enable.
//  Sits between a producer and a slow or enable-gated capture register that STA
//  constrains with set_multicycle_path -setup MCP_CYCLES.
// PARAMETERS
//  WIDTH        8   width of the data word
//  MCP_CYCLES   2   setup multiplier; legal range 2..16; capture edge = launch edge + MCP_CYCLES
//  HOLD_CYCLES  0   extra edges the launch data stays frozen after the capture edge; range 0..15
// PORTS
//  clk          in   1      single clock
//  rst          in   1      asynchronous reset, active-high
//  in_valid     in   1      producer has a word
//  in_data      in   WIDTH  producer word
//  in_ready     out  1      block can accept a word this cycle
//  flush        in   1      synchronous abort of the in-flight transfer
//  launch_data  out  WIDTH  registered launch flop; the only data path to the destination
//  cap_en       out  1      one-cycle capture qualifier for the destination
//  busy         out  1      a transfer is in flight (state != IDLE)
//  xfer_cnt     out  16     count of completed captures; wraps 16'hFFFF -> 0
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, cnt=0, launch_data=0, cap_en=0, busy=0,
//   xfer_cnt=0. in_ready=1 once rst deasserts.
//  Accept: occurs at a rising edge where in_valid && in_ready. That edge is the
//   launch edge E0: launch_data<=in_data, cnt<=0, state<=SETUP.
//   in_valid while in_ready=0 is ignored; the producer must hold it.
//  SETUP: cnt increments on each edge. launch_data is frozen.
//   cap_en = (state==SETUP && cnt==MCP_CYCLES-1); it is combinational from registered
//   state only, with no input-to-output path. The destination samples at edge
//   E0+MCP_CYCLES. At that edge xfer_cnt increments.
//   Next state: HOLD if HOLD_CYCLES>0 (cnt<=0), otherwise IDLE.
//  HOLD: launch_data frozen, in_ready=0. After HOLD_CYCLES edges -> IDLE.
//  in_ready = (state==IDLE) || (cap_en && HOLD_CYCLES==0 && !flush).
//   The second term gives back-to-back transfers: a new launch on the capture edge
//   itself. Destination hold is met because same-edge capture sees the old value.
//   Throughput is then 1 word per MCP_CYCLES cycles.
//   With HOLD_CYCLES>0, the period is MCP_CYCLES+HOLD_CYCLES+1.
//  flush (synchronous, in SETUP or HOLD): next state IDLE; cap_en forced 0 that cycle;
//   xfer_cnt not incremented; launch_data keeps its value. flush in IDLE has no effect,
//   and flush blocks an accept in that same cycle.
//  Simultaneous flush and cap_en cycle: flush wins; no capture is counted.
//  Reset mid-transfer: cap_en drops asynchronously and no capture is counted.
//   launch_data clears to 0.
//  cnt width: $clog2(16) bits; cnt never exceeds max(MCP_CYCLES-1, HOLD_CYCLES-1).
//  Elaboration check: an out-of-range parameter triggers $error.
// STRUCTURE
//  Package mcp_pkg: typedef enum logic [1:0] {IDLE, SETUP, HOLD} mcp_state_e;
//   localparams MCP_MAX=16 and HOLD_MAX=15; CNT_W=$clog2(MCP_MAX).
//  Sub-module mcp_cycle_counter: loadable up-counter with clr/en and a
//   terminal-match output. One instance is shared by SETUP and HOLD, with the match
//   value muxed per state.
//  The top contains the FSM, launch register, in_ready/cap_en decode and xfer_cnt.
//  Launch register and FSM flops are in the clk domain only; no clock gating inside.
// TESTING
//  1 MCP=2,HOLD=0: send 8'hA5 at E0 -> cap_en=1 only in cycle E1..E2;
//    launch_data=8'hA5 stable E0..E2; xfer_cnt=1.
//  2 MCP=4,HOLD=0: continuous in_valid with words 1,2,3 -> launches every 4 cycles;
//    exactly one cap_en per word; in_ready=1 only in IDLE and cap_en cycles; xfer_cnt=3.
//  3 MCP=3,HOLD=2: two words back-to-back -> second launch 6 cycles after the first;
//    in_ready=0 through both HOLD cycles.
//  4 MCP=4: flush at cnt=1 -> no cap_en, xfer_cnt unchanged, IDLE next cycle.
//    Then flush coincident with cap_en -> cap_en=0, xfer_cnt unchanged.
//  5 Assert rst asynchronously mid-SETUP -> cap_en, busy and launch_data=0 before the
//    next edge; after release, a fresh transfer completes normally.
//  6 Preload 65535 transfers (force xfer_cnt) then 1 transfer -> xfer_cnt wraps to 0.
//    Assertion throughout: launch_data changes only on an accept edge.

Source files
------------

// File: rtl/mcp_pkg.sv
// Shared types and limits for the multicycle-path launch controller.
// The cycle counter is sized for the largest legal setup multiplier.
package mcp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    HOLD
  } mcp_state_e;

  localparam int MCP_MAX  = 16;
  localparam int HOLD_MAX = 15;
  localparam int CNT_W    = $clog2(MCP_MAX);

endpackage

// File: rtl/mcp_cycle_counter.sv
// Clearable up-counter with a terminal-match flag against a supplied value.
// Clear has priority over enable.
module mcp_cycle_counter
  import mcp_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] match_val,
  output logic         match
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign match = (count_q == match_val);

endmodule

// File: rtl/mcp_launch_ctrl.sv
// Launch side of a multicycle-path transfer: registers one word, holds it frozen
// for the setup and hold windows, and qualifies the destination capture edge.
module mcp_launch_ctrl
  import mcp_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int MCP_CYCLES  = 2,
  parameter int HOLD_CYCLES = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             flush,
  output logic [WIDTH-1:0] launch_data,
  output logic             cap_en,
  output logic             busy,
  output logic [15:0]      xfer_cnt
);

  if (MCP_CYCLES < 2 || MCP_CYCLES > MCP_MAX) begin : g_bad_mcp
    $error("mcp_launch_ctrl: MCP_CYCLES out of range 2..16");
  end
  if (HOLD_CYCLES < 0 || HOLD_CYCLES > HOLD_MAX) begin : g_bad_hold
    $error("mcp_launch_ctrl: HOLD_CYCLES out of range 0..15");
  end

  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(MCP_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);

  mcp_state_e       state_q, state_d;
  logic [WIDTH-1:0] launch_q, launch_d;
  logic [15:0]      xfer_cnt_q, xfer_cnt_d;
  logic             cnt_clr, cnt_en, cnt_match;
  logic [CNT_W-1:0] match_val;
  logic             accept;

  // One counter serves both windows; only the terminal value changes with state.
  assign match_val = (state_q == HOLD) ? HOLD_LAST : SETUP_LAST;

  mcp_cycle_counter #(.W(CNT_W)) u_cnt (
    .clk       (clk),
    .rst       (rst),
    .clr       (cnt_clr),
    .en        (cnt_en),
    .match_val (match_val),
    .match     (cnt_match)
  );

  assign cap_en   = (state_q == SETUP) && cnt_match && !flush;
  assign in_ready = (state_q == IDLE) || (cap_en && (HOLD_CYCLES == 0) && !flush);
  assign accept   = in_valid && in_ready && !flush;
  assign busy     = (state_q != IDLE);

  always_comb begin
    state_d    = state_q;
    launch_d   = launch_q;
    xfer_cnt_d = xfer_cnt_q;
    cnt_clr    = 1'b1;
    cnt_en     = 1'b0;
    if (accept) begin
      launch_d = in_data;
    end
    case (state_q)
      IDLE: begin
        if (accept) state_d = SETUP;
      end
      SETUP: begin
        if (flush) begin
          state_d = IDLE;
        end else if (cnt_match) begin
          xfer_cnt_d = xfer_cnt_q + 16'd1;
          if (accept)               state_d = SETUP;
          else if (HOLD_CYCLES > 0) state_d = HOLD;
          else                      state_d = IDLE;
        end else begin
          cnt_clr = 1'b0;
          cnt_en  = 1'b1;
        end
      end
      HOLD: begin
        if (flush || cnt_match) begin
          state_d = IDLE;
        end else begin
          cnt_clr = 1'b0;
          cnt_en  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      launch_q   <= '0;
      xfer_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      launch_q   <= launch_d;
      xfer_cnt_q <= xfer_cnt_d;
    end
  end

  assign launch_data = launch_q;
  assign xfer_cnt    = xfer_cnt_q;

endmodule

// File: tb/tb_mcp_launch_ctrl.sv
// Randomized bench driving three differently parameterized launch controllers
// against a timeline model: each word is captured MCP edges after its launch.
module tb_mcp_launch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  in_valid;
  logic [2:0]  flush;
  logic [2:0]  in_ready;
  logic [2:0]  cap_en;
  logic [2:0]  busy;
  logic [7:0]  in_data     [3];
  logic [7:0]  launch_data [3];
  logic [15:0] xfer_cnt    [3];

  int n_tests = 0;
  int n_fail  = 0;

  int          mcp_p  [3] = '{2, 4, 3};
  int          hold_p [3] = '{0, 0, 2};
  bit          m_active [3];
  int          m_launch [3];
  logic [7:0]  m_data   [3];
  logic [15:0] m_xfer   [3];
  int          cyc;
  logic [2:0]  rv, rf;

  always #5 clk = ~clk;

  mcp_launch_ctrl #(.WIDTH(8), .MCP_CYCLES(2), .HOLD_CYCLES(0)) u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_data(in_data[0]),
    .in_ready(in_ready[0]), .flush(flush[0]), .launch_data(launch_data[0]),
    .cap_en(cap_en[0]), .busy(busy[0]), .xfer_cnt(xfer_cnt[0]));

  mcp_launch_ctrl #(.WIDTH(8), .MCP_CYCLES(4), .HOLD_CYCLES(0)) u_b (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_data(in_data[1]),
    .in_ready(in_ready[1]), .flush(flush[1]), .launch_data(launch_data[1]),
    .cap_en(cap_en[1]), .busy(busy[1]), .xfer_cnt(xfer_cnt[1]));

  mcp_launch_ctrl #(.WIDTH(8), .MCP_CYCLES(3), .HOLD_CYCLES(2)) u_c (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_data(in_data[2]),
    .in_ready(in_ready[2]), .flush(flush[2]), .launch_data(launch_data[2]),
    .cap_en(cap_en[2]), .busy(busy[2]), .xfer_cnt(xfer_cnt[2]));

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 3; i++) begin
      m_active[i] = 1'b0;
      m_launch[i] = 0;
      m_data[i]   = 8'h00;
      m_xfer[i]   = 16'h0000;
    end
  endtask

  // One clock: drive at negedge, check the model's view of this cycle, then
  // advance the model across the rising edge.
  task automatic applyStimulus(input logic [2:0] v, input logic [2:0] f,
                               input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2);
    bit infl [3];
    bit cap  [3];
    bit rdy  [3];
    @(negedge clk);
    in_valid   = v;
    flush      = f;
    in_data[0] = d0;
    in_data[1] = d1;
    in_data[2] = d2;
    #1;
    for (int i = 0; i < 3; i++) begin
      int age;
      age     = cyc - m_launch[i];
      infl[i] = m_active[i] && (age < mcp_p[i] + hold_p[i]);
      cap[i]  = infl[i] && (age == mcp_p[i] - 1) && !f[i];
      rdy[i]  = !infl[i] || (cap[i] && hold_p[i] == 0);
      checkOutput($sformatf("cap_en[%0d]@%0d", i, cyc), 32'(cap_en[i]), 32'(cap[i]));
      checkOutput($sformatf("in_ready[%0d]@%0d", i, cyc), 32'(in_ready[i]), 32'(rdy[i]));
      checkOutput($sformatf("busy[%0d]@%0d", i, cyc), 32'(busy[i]), 32'(infl[i]));
      checkOutput($sformatf("launch_data[%0d]@%0d", i, cyc), 32'(launch_data[i]), 32'(m_data[i]));
      checkOutput($sformatf("xfer_cnt[%0d]@%0d", i, cyc), 32'(xfer_cnt[i]), 32'(m_xfer[i]));
    end
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (cap[i]) m_xfer[i] = m_xfer[i] + 16'd1;
      if (f[i] && infl[i]) m_active[i] = 1'b0;
      if (v[i] && rdy[i] && !f[i]) begin
        m_active[i] = 1'b1;
        m_launch[i] = cyc + 1;
        m_data[i]   = in_data[i];
      end
    end
    cyc++;
  endtask

  task automatic drain(input int n);
    for (int k = 0; k < n; k++) applyStimulus(3'b000, 3'b000, 8'h00, 8'h00, 8'h00);
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 3'b000;
    flush    = 3'b000;
    for (int i = 0; i < 3; i++) in_data[i] = 8'h00;
    modelReset();
    cyc = 0;

    #12;
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("rst_cap_en[%0d]", i), 32'(cap_en[i]), 32'd0);
      checkOutput($sformatf("rst_busy[%0d]", i), 32'(busy[i]), 32'd0);
      checkOutput($sformatf("rst_launch_data[%0d]", i), 32'(launch_data[i]), 32'd0);
      checkOutput($sformatf("rst_xfer_cnt[%0d]", i), 32'(xfer_cnt[i]), 32'd0);
    end
    rst = 1'b0;

    applyStimulus(3'b111, 3'b000, 8'hA5, 8'hA5, 8'hA5);
    drain(8);

    for (int k = 1; k <= 14; k++) applyStimulus(3'b111, 3'b000, 8'(k), 8'(k), 8'(k));
    drain(8);

    // Flush one edge into SETUP (also lands on the MCP=2 capture cycle).
    applyStimulus(3'b111, 3'b000, 8'h11, 8'h22, 8'h33);
    drain(1);
    applyStimulus(3'b000, 3'b111, 8'h00, 8'h00, 8'h00);
    drain(8);
    // Flush on the MCP=4 capture cycle, with a competing in_valid.
    applyStimulus(3'b111, 3'b000, 8'h44, 8'h55, 8'h66);
    drain(3);
    applyStimulus(3'b111, 3'b111, 8'h77, 8'h88, 8'h99);
    drain(8);

    // Asynchronous reset in the middle of SETUP.
    applyStimulus(3'b111, 3'b000, 8'h3C, 8'h5A, 8'h96);
    drain(1);
    #2;
    checkOutput("cap_en_before_rst[0]", 32'(cap_en[0]), 32'd1);
    rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("async_rst_cap_en[%0d]", i), 32'(cap_en[i]), 32'd0);
      checkOutput($sformatf("async_rst_busy[%0d]", i), 32'(busy[i]), 32'd0);
      checkOutput($sformatf("async_rst_launch_data[%0d]", i), 32'(launch_data[i]), 32'd0);
    end
    modelReset();
    @(negedge clk);
    #2 rst = 1'b0;
    applyStimulus(3'b111, 3'b000, 8'hC3, 8'hD4, 8'hE5);
    drain(8);

    // Preload the capture count to its maximum, then let one transfer wrap it.
    @(negedge clk);
    force u_a.xfer_cnt_d = 16'hFFFF;
    force u_b.xfer_cnt_d = 16'hFFFF;
    force u_c.xfer_cnt_d = 16'hFFFF;
    @(posedge clk);
    #1;
    release u_a.xfer_cnt_d;
    release u_b.xfer_cnt_d;
    release u_c.xfer_cnt_d;
    for (int i = 0; i < 3; i++) m_xfer[i] = 16'hFFFF;
    cyc++;
    for (int i = 0; i < 3; i++)
      checkOutput($sformatf("xfer_preload[%0d]", i), 32'(xfer_cnt[i]), 32'hFFFF);
    applyStimulus(3'b111, 3'b000, 8'h5E, 8'h6F, 8'h70);
    drain(8);
    for (int i = 0; i < 3; i++)
      checkOutput($sformatf("xfer_wrap[%0d]", i), 32'(xfer_cnt[i]), 32'h0000);

    for (int k = 0; k < 800; k++) begin
      for (int i = 0; i < 3; i++) begin
        rv[i] = ($urandom_range(0, 3) != 0);
        rf[i] = ($urandom_range(0, 15) == 0);
      end
      applyStimulus(rv, rf, 8'($urandom), 8'($urandom), 8'($urandom));
    end
    drain(8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
